uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 1085, meaning clk cycles per UART bit (125MHz/115.2kbps), minimum 2.
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 65535, meaning idle cycles before a locked grant is forcibly released (0 = never).
REQ-004 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port: arst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port: req_valid  input  NREQ  per-requester byte valid.
REQ-007 Port: req_data  input  NREQ*8  per-requester byte, requester i in bits [8i+7:8i].
REQ-008 Port: req_last  input  NREQ  marks last byte of a message.
REQ-009 Port: req_ready  output  NREQ  byte accepted when valid&ready on a clk edge.
REQ-010 Port: gnt  output  NREQ  one-hot current owner, all-zero when unowned.
REQ-011 Port: uart_tx  output  1  serial line, 8 data bits, no parity, 1 stop bit, LSB first, idle high.
REQ-012 Port: busy  output  1  high while locked or a frame is on the line.
REQ-013 Port: timeout_err  output  1  one-cycle pulse when a grant is forcibly released.

Function
REQ-014 The arbiter FSM SHALL have states ARB_IDLE and ARB_LOCK.
REQ-015 In ARB_IDLE with any req_valid, the next-cycle gnt SHALL select, round-robin, the first valid requester starting at (last_owner+1) mod NREQ; FSM goes to ARB_LOCK.
REQ-016 In ARB_IDLE with no valid, gnt SHALL stay zero and FSM SHALL stay in ARB_IDLE.
REQ-017 req_ready[i] SHALL be combinational gnt[i] AND serializer-idle; at most one bit set.
REQ-018 Latency from req_valid rising (arbiter idle, line idle) to req_ready SHALL be exactly 1 cycle.
REQ-019 An accepted byte with req_last=1 SHALL return FSM to ARB_IDLE next cycle, clear gnt, and record owner as last_owner.
REQ-020 Grant SHALL be held across gaps in req_valid of the owner; other requesters SHALL NOT be served until release.
REQ-021 If LOCK_TIMEOUT>0 and the owner holds no valid for LOCK_TIMEOUT consecutive cycles with serializer idle, FSM SHALL release as in REQ-019 and pulse timeout_err.
REQ-022 Serializer on accept SHALL drive uart_tx low starting the next cycle; START, D0..D7, STOP each last exactly CLKS_PER_BIT cycles.
REQ-023 Serializer SHALL return idle on the last STOP cycle's following edge, so back-to-back bytes have a frame period of exactly 10*CLKS_PER_BIT cycles with no extra idle.
REQ-024 Bit counter SHALL count 0..9 and the baud counter 0..CLKS_PER_BIT-1, both wrapping to 0; width $clog2 of the bound.
REQ-025 Accepted req_data SHALL be latched at acceptance; later changes on req_data SHALL NOT affect the frame.
REQ-026 Last byte with req_last=1 SHALL still be fully serialized after grant release; new grant MAY be issued during it, its ready waiting for serializer idle.
REQ-027 busy SHALL equal (FSM==ARB_LOCK) OR serializer not idle.
REQ-028 A request valid during the release cycle of another requester SHALL be considered in the following ARB_IDLE cycle.

Reset
REQ-029 On arst_n low: FSM=ARB_IDLE, gnt=0, req_ready=0, last_owner=NREQ-1 (so requester 0 wins first), uart_tx=1, busy=0, timeout_err=0, all counters 0.
REQ-030 Reset asserted mid-frame SHALL immediately force uart_tx=1 and abandon the frame; deassertion SHALL be synchronized before FSM advance.

Structure
REQ-031 Package uart_pkg SHALL hold the arbiter state enum, serializer state enum (SER_IDLE, SER_SHIFT) and UART frame constants (DATA_BITS=8, FRAME_BITS=10).
REQ-032 The serializer SHALL be sub-module uart_tx_ser (ports clk, arst_n, valid, data, ready, uart_tx); arbitration stays in uart_tx_arb.

Verification (bench: NREQ=4, CLKS_PER_BIT=4, LOCK_TIMEOUT=20)
REQ-033 Reset release, no requests -> uart_tx=1, gnt=0, busy=0 for 100 cycles.
REQ-034 Req0 sends 0x55 last=1 -> ready 1 cycle after valid; uart_tx = 0,1,0,1,0,1,0,1,0,1 each 4 cycles; frame 40 cycles.
REQ-035 Req1 sends 3-byte message 0x41,0x42,0x43(last) while req2 valid -> req2 granted only after 0x43 accepted; byte starts 40 cycles apart.
REQ-036 All four requesters continuously valid, 1-byte messages -> grant order 0,1,2,3,0 with no requester starved.
REQ-037 Req3 sends 0x10 last=0 then drops valid -> timeout_err pulses after 20 idle cycles, gnt clears, req0 then served.
REQ-038 arst_n pulsed low during D3 of a frame -> uart_tx=1 immediately, gnt=0; post-reset request frames cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and UART frame constants for the multi-
//                requester UART transmitter (arbiter FSM state, serializer
//                FSM state, frame geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 8N1 framing: one start bit, eight data bits, one stop bit.
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_ser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_ser
//  Description : 8N1 UART serializer. Latches a byte on valid&ready and
//                shifts START, D0..D7 (LSB first), STOP, each held for
//                CLKS_PER_BIT clocks. Idle line is high.
//  Ports       : clk     - clock, rising edge
//                arst_n  - asynchronous active-low reset
//                valid   - byte offered
//                data    - byte to send
//                ready   - byte taken on this edge when valid is high
//                uart_tx - serial line output (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 uart_tx
);

    localparam int c_baud_w = $clog2(CLKS_PER_BIT);
    localparam int c_bit_w  = $clog2(FRAME_BITS);

    localparam logic [c_baud_w-1:0] c_baud_last     = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_bit_w-1:0]  c_bit_stop      = c_bit_w'(FRAME_BITS - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last_data = c_bit_w'(DATA_BITS);

    ser_state_t            r_state;
    logic [c_baud_w-1:0]   r_baud;
    logic [c_bit_w-1:0]    r_bit;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_tx;

    logic w_bit_end;
    logic w_frame_end;
    logic w_accept;

    assign w_bit_end   = (r_baud == c_baud_last);
    assign w_frame_end = (r_state == SER_SHIFT) && (r_bit == c_bit_stop) && w_bit_end;

    // Ready already in the final STOP cycle so a queued byte starts on the
    // very next edge: back-to-back frames then have no idle gap.
    assign ready    = (r_state == SER_IDLE) || w_frame_end;
    assign w_accept = valid && ready;
    assign uart_tx  = r_tx;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= SER_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else if (w_accept) begin
            r_state <= SER_SHIFT;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= data;
            r_tx    <= 1'b0;
        end else if (r_state == SER_SHIFT) begin
            if (w_bit_end) begin
                r_baud <= '0;
                if (r_bit == c_bit_stop) begin
                    r_state <= SER_IDLE;
                    r_bit   <= '0;
                    r_tx    <= 1'b1;
                end else begin
                    r_bit <= r_bit + 1'b1;
                    // r_bit names the bit just finished; the next one is driven.
                    if (r_bit == c_bit_last_data) begin
                        r_tx <= 1'b1;
                    end else begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
                    end
                end
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arb
//  Description : Round-robin, message-locked arbiter in front of a single
//                UART serializer. A requester keeps the grant until it hands
//                over a byte marked last, or until it stays silent for
//                LOCK_TIMEOUT cycles while the line is free.
//  Ports       : clk         - clock, rising edge
//                arst_n      - asynchronous active-low reset
//                req_valid   - per-requester byte valid  [NREQ]
//                req_data    - per-requester byte        [NREQ*8]
//                req_last    - last byte of a message    [NREQ]
//                req_ready   - byte accepted this edge   [NREQ]
//                gnt         - one-hot current owner     [NREQ]
//                uart_tx     - serial line, idle high
//                busy        - locked or frame in flight
//                timeout_err - one-cycle pulse on forced release
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int CLKS_PER_BIT = 1085,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   gnt,
    output logic              uart_tx,
    output logic              busy,
    output logic              timeout_err
);

    localparam int               c_idx_w = $clog2(NREQ);
    localparam logic [NREQ-1:0]  c_one   = NREQ'(1);

    // Reset asserts immediately, releases two edges after arst_n rises.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    arb_state_t            r_state;
    logic [NREQ-1:0]       r_gnt;
    logic [c_idx_w-1:0]    r_owner;
    logic [c_idx_w-1:0]    r_last_owner;
    logic                  r_timeout_err;

    logic                  w_ser_ready;
    logic                  w_owner_valid;
    logic                  w_owner_last;
    logic [DATA_BITS-1:0]  w_owner_data;
    logic                  w_accept;
    logic                  w_idle_cycle;
    logic                  w_expire;
    logic                  w_pick_found;
    logic [c_idx_w-1:0]    w_pick_idx;
    logic [c_idx_w-1:0]    w_cand;

    // Round-robin search starting one past the previous owner.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = c_idx_w'((int'(r_last_owner) + k) % NREQ);
            if (!w_pick_found && req_valid[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    assign w_owner_valid = req_valid[r_owner];
    assign w_owner_last  = req_last[r_owner];
    assign w_owner_data  = req_data[r_owner*8 +: 8];

    // r_gnt is zero outside ARB_LOCK, so this also gates ready by state.
    assign req_ready = r_gnt & {NREQ{w_ser_ready}};
    assign w_accept  = (r_state == ARB_LOCK) && w_owner_valid && w_ser_ready;

    // Silent owner with a free line: the cycles that count toward timeout.
    assign w_idle_cycle = (r_state == ARB_LOCK) && !w_owner_valid && w_ser_ready;

    generate
        if (LOCK_TIMEOUT > 0) begin : g_timeout
            localparam int c_to_w = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
            logic [c_to_w-1:0] r_idle_cnt;

            assign w_expire = w_idle_cycle && (r_idle_cnt == c_to_w'(LOCK_TIMEOUT - 1));

            always_ff @(posedge clk or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_idle_cnt <= '0;
                end else if (w_idle_cycle && !w_expire) begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end else begin
                    r_idle_cnt <= '0;
                end
            end
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= ARB_IDLE;
            r_gnt         <= '0;
            r_owner       <= '0;
            r_last_owner  <= c_idx_w'(NREQ - 1);
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_found) begin
                        r_state <= ARB_LOCK;
                        r_gnt   <= c_one << w_pick_idx;
                        r_owner <= w_pick_idx;
                    end
                end
                ARB_LOCK: begin
                    if (w_accept && w_owner_last) begin
                        r_state      <= ARB_IDLE;
                        r_gnt        <= '0;
                        r_last_owner <= r_owner;
                    end else if (w_expire) begin
                        r_state       <= ARB_IDLE;
                        r_gnt         <= '0;
                        r_last_owner  <= r_owner;
                        r_timeout_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    uart_tx_ser #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk     (clk),
        .arst_n  (w_rst_n),
        .valid   (w_accept),
        .data    (w_owner_data),
        .ready   (w_ser_ready),
        .uart_tx (uart_tx)
    );

    assign gnt         = r_gnt;
    assign timeout_err = r_timeout_err;
    // A serializer able to take a byte counts as idle: its last STOP cycle
    // is the hand-over point to the next frame.
    assign busy        = (r_state == ARB_LOCK) || !w_ser_ready;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arb
//  Description : Scoreboard bench for uart_tx_arb (NREQ=4, CLKS_PER_BIT=4,
//                LOCK_TIMEOUT=20). Stimulus queues bytes per requester and
//                pushes expected acceptances and frames; monitors pop and
//                compare as the DUT accepts bytes and drives frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

    localparam int NREQ = 4;
    localparam int CPB  = 4;
    localparam int LT   = 20;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  gnt;
    logic        uart_tx;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .NREQ         (NREQ),
        .CLKS_PER_BIT (CPB),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .gnt         (gnt),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct packed { logic [7:0] d; logic l; } drv_t;
    typedef struct packed { logic [1:0] idx; logic [7:0] d; } acc_t;

    drv_t       drv_q [4][$];
    acc_t       exp_acc[$];
    logic [7:0] exp_frame[$];
    int         fstart[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int to_seen  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_ready(input int i, input int budget, output int c, output bit ok);
        ok = 0;
        c  = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (req_valid[i] && req_ready[i]) begin
                ok = 1;
                c  = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (exp_acc.size() == 0 && exp_frame.size() == 0 && busy === 1'b0 && uart_tx === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check(name, 32'(ok), 1);
    endtask

    // Requester driver: one byte per queue head, popped after acceptance.
    initial begin
        logic [3:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
                if (drv_q[i].size() > 0) begin
                    req_valid[i]      = 1'b1;
                    req_data[8*i +: 8] = drv_q[i][0].d;
                    req_last[i]       = drv_q[i][0].l;
                end else begin
                    req_valid[i]      = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]       = 1'b0;
                end
            end
        end
    end

    // Acceptance monitor.
    logic [3:0] mon_w;
    acc_t       mon_e;
    always @(negedge clk) begin
        if (arst_n === 1'b1) begin
            mon_w = req_valid & req_ready;
            if (mon_w != 4'b0) begin
                if (exp_acc.size() == 0) begin
                    check("acc_unexpected", 32'(mon_w), 0);
                end else begin
                    mon_e = exp_acc.pop_front();
                    check("acc_requester", 32'(mon_w), 32'(4'b0001 << mon_e.idx));
                    check("acc_data", 32'(req_data[8*mon_e.idx +: 8]), 32'(mon_e.d));
                end
            end
        end
    end

    // Line monitor: decodes frames at mid-bit, abandons on reset.
    initial begin
        logic [9:0] bits;
        bit         aborted;
        int         s;
        forever begin
            @(negedge clk);
            if (arst_n === 1'b1 && uart_tx === 1'b0) begin
                s       = cyc;
                aborted = 0;
                bits    = '0;
                for (int k = 0; k < 10; k++) begin
                    for (int w = 0; w < ((k == 0) ? 2 : CPB); w++) begin
                        @(negedge clk);
                        if (arst_n !== 1'b1) begin
                            aborted = 1;
                            break;
                        end
                    end
                    if (aborted) break;
                    bits[k] = uart_tx;
                end
                if (!aborted) begin
                    fstart.push_back(s);
                    check("frame_start_bit", 32'(bits[0]), 0);
                    check("frame_stop_bit", 32'(bits[9]), 1);
                    if (exp_frame.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame_unexpected: got 0x%0h, expected no frame (cycle %0d)", bits[8:1], cyc);
                    end else begin
                        check("frame_data", 32'(bits[8:1]), 32'(exp_frame.pop_front()));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (timeout_err === 1'b1) to_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000 ns");
        $fatal(1);
    end

    initial begin
        int vcyc, rcyc, acyc, tcyc, n0, d;
        int bad_tx, bad_gnt, bad_busy;
        bit ok, found;

        // Reset state
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", 32'(uart_tx), 1);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        @(posedge clk);
        #2 arst_n = 1'b1;

        // Quiet line for 100 cycles
        bad_tx = 0; bad_gnt = 0; bad_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) bad_tx++;
            if (gnt !== 4'b0) bad_gnt++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("idle_tx_bad_cycles", 32'(bad_tx), 0);
        check("idle_gnt_bad_cycles", 32'(bad_gnt), 0);
        check("idle_busy_bad_cycles", 32'(bad_busy), 0);

        // Single byte 0x55 from requester 0, one-cycle ready latency
        @(posedge clk); #1;
        drv_q[0].push_back('{d: 8'h55, l: 1'b1});
        exp_acc.push_back('{idx: 2'd0, d: 8'h55});
        exp_frame.push_back(8'h55);
        found = 0;
        vcyc  = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (req_valid[0]) begin found = 1; vcyc = cyc; break; end
        end
        check("t1_valid_driven", 32'(found), 1);
        if (req_ready[0]) rcyc = cyc;
        else wait_ready(0, 10, rcyc, ok);
        check("t1_ready_latency", 32'(rcyc - vcyc), 1);
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_busy_locked", 32'(busy), 1);
        wait_idle(200, "t1_idle_reached");

        // 3-byte message from req1 while req2 waits
        n0 = fstart.size();
        @(posedge clk); #1;
        drv_q[1].push_back('{d: 8'h41, l: 1'b0});
        drv_q[1].push_back('{d: 8'h42, l: 1'b0});
        drv_q[1].push_back('{d: 8'h43, l: 1'b1});
        drv_q[2].push_back('{d: 8'h99, l: 1'b1});
        exp_acc.push_back('{idx: 2'd1, d: 8'h41});
        exp_acc.push_back('{idx: 2'd1, d: 8'h42});
        exp_acc.push_back('{idx: 2'd1, d: 8'h43});
        exp_acc.push_back('{idx: 2'd2, d: 8'h99});
        exp_frame.push_back(8'h41);
        exp_frame.push_back(8'h42);
        exp_frame.push_back(8'h43);
        exp_frame.push_back(8'h99);
        wait_idle(400, "t2_idle_reached");
        check("t2_frame_count", 32'(fstart.size() - n0), 4);
        if (fstart.size() >= n0 + 4) begin
            check("t2_period_41_42", 32'(fstart[n0+1] - fstart[n0]), 40);
            check("t2_period_42_43", 32'(fstart[n0+2] - fstart[n0+1]), 40);
            check("t2_period_43_99", 32'(fstart[n0+3] - fstart[n0+2]), 40);
        end

        // Lock timeout: req3 sends 0x10 without last, req0 waits
        @(posedge clk); #1;
        drv_q[3].push_back('{d: 8'h10, l: 1'b0});
        drv_q[0].push_back('{d: 8'h20, l: 1'b1});
        exp_acc.push_back('{idx: 2'd3, d: 8'h10});
        exp_acc.push_back('{idx: 2'd0, d: 8'h20});
        exp_frame.push_back(8'h10);
        exp_frame.push_back(8'h20);
        wait_ready(3, 20, acyc, ok);
        check("t4_req3_accepted", 32'(ok), 1);
        found = 0;
        tcyc  = 0;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin found = 1; tcyc = cyc; break; end
        end
        check("t4_timeout_seen", 32'(found), 1);
        if (found) begin
            // 40-cycle frame plus 20 silent cycles, allowing for where the
            // first silent cycle is counted relative to the STOP bit.
            d = tcyc - (acyc + 1);
            check("t4_timeout_delay_in_58_61", 32'(d >= 58 && d <= 61), 1);
            check("t4_gnt_cleared", 32'(gnt), 0);
            check("t4_req0_still_pending", 32'(exp_acc.size()), 1);
            @(negedge clk);
            check("t4_timeout_one_cycle", 32'(timeout_err), 0);
        end
        wait_idle(200, "t4_idle_reached");
        check("t4_timeout_pulse_count", 32'(to_seen), 1);

        // Reset during D3 of a frame from req0
        @(posedge clk); #1;
        drv_q[0].push_back('{d: 8'hC3, l: 1'b0});
        exp_acc.push_back('{idx: 2'd0, d: 8'hC3});
        wait_ready(0, 20, acyc, ok);
        check("t5_req0_accepted", 32'(ok), 1);
        @(posedge clk);
        repeat (17) @(posedge clk);
        #1;
        check("t5_tx_low_in_d3", 32'(uart_tx), 0);
        check("t5_gnt_held", 32'(gnt), 32'h1);
        #1 arst_n = 1'b0;
        #1;
        check("t5_tx_forced_high", 32'(uart_tx), 1);
        check("t5_gnt_cleared", 32'(gnt), 0);
        check("t5_busy_cleared", 32'(busy), 0);
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // All four continuously valid with 1-byte messages after reset
        drv_q[0].push_back('{d: 8'hA0, l: 1'b1});
        drv_q[0].push_back('{d: 8'hB0, l: 1'b1});
        drv_q[1].push_back('{d: 8'hA1, l: 1'b1});
        drv_q[2].push_back('{d: 8'hA2, l: 1'b1});
        drv_q[3].push_back('{d: 8'hA3, l: 1'b1});
        exp_acc.push_back('{idx: 2'd0, d: 8'hA0});
        exp_acc.push_back('{idx: 2'd1, d: 8'hA1});
        exp_acc.push_back('{idx: 2'd2, d: 8'hA2});
        exp_acc.push_back('{idx: 2'd3, d: 8'hA3});
        exp_acc.push_back('{idx: 2'd0, d: 8'hB0});
        exp_frame.push_back(8'hA0);
        exp_frame.push_back(8'hA1);
        exp_frame.push_back(8'hA2);
        exp_frame.push_back(8'hA3);
        exp_frame.push_back(8'hB0);
        wait_idle(600, "t3_idle_reached");

        check("end_acc_queue_empty", 32'(exp_acc.size()), 0);
        check("end_frame_queue_empty", 32'(exp_frame.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
